// File: rtl/shifter_test_pkg.sv
// rtl/shifter_test_pkg.sv - shared types and constants for the chain SET-test controller
package shifter_test_pkg;
   typedef enum logic [1:0] {IDLE, FILL, MONITOR, REPORT} state_t;
   localparam int CNT_W_DEF  = 12;
   localparam int TIMER_W    = 32;
   localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/shift_upset_counter.sv
// rtl/shift_upset_counter.sv - per-chain synchronizer, departure detect and saturating upset counter
module shift_upset_counter
   import shifter_test_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_async,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic             i_expected,
   output logic             o_sync,
   output logic [CNT_W-1:0] o_count
);
   logic [SYNC_DEPTH-1:0] r_sync;
   logic                  r_prev;
   logic [CNT_W-1:0]      r_count;
   logic                  w_event;
   logic                  w_sat;

   // Only the transition away from the expected level counts, so a held wrong level is one upset.
   assign w_event = (r_prev == i_expected) && (r_sync[SYNC_DEPTH-1] != i_expected);
   assign w_sat   = &r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync  <= '1;
         r_prev  <= 1'b1;
         r_count <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_DEPTH-2:0], i_async};
         r_prev <= r_sync[SYNC_DEPTH-1];
         if (i_clear)
            r_count <= '0;
         else if (i_enable && w_event && !w_sat)
            r_count <= r_count + 1'b1;
      end
   end

   assign o_sync  = r_sync[SYNC_DEPTH-1];
   assign o_count = r_count;
endmodule

// File: rtl/shifter_test_ctrl.sv
// rtl/shifter_test_ctrl.sv - SET-test run sequencer for two shift chains
// Optional SHIFTER_AUTO_RERUN_EN: back-to-back monitor windows with held result counts.
module shifter_test_ctrl
   import shifter_test_pkg::*;
#(
   parameter int          FILL_CYCLES   = 64,
   parameter logic [31:0] WINDOW_CYCLES = 32'd1000000,
   parameter int          CNT_W         = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             STOP,
   input  logic             PATTERN,
   input  logic             SHIFT_OUT0,
   input  logic             SHIFT_OUT1,
   output logic             SHIFT_INPUT0,
   output logic             SHIFT_INPUT1,
   output logic [CNT_W-1:0] SHIFT_ERROR_COUNT0,
   output logic [CNT_W-1:0] SHIFT_ERROR_COUNT1,
   output logic [1:0]       CHAIN_FAULT,
   output logic             BUSY,
   output logic             DONE
);
   localparam logic [TIMER_W-1:0] FILL_LAST = TIMER_W'(FILL_CYCLES - 1);
   localparam logic [TIMER_W-1:0] WIN_LAST  = TIMER_W'(WINDOW_CYCLES - 32'd1);

   state_t               r_state, w_state_nxt;
   logic [TIMER_W-1:0]   r_timer;
   logic                 r_pattern;
   logic [1:0]           r_fault;
   logic                 r_busy, r_done;
   logic                 w_start_run, w_clear, w_capture, w_timer_clr, w_enable;
   logic                 w_busy_nxt, w_done_nxt;
   logic                 w_sync0, w_sync1;
   logic [CNT_W-1:0]     w_cnt0, w_cnt1;

   always_ff @(posedge CLK) begin
      if (!RST)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (START && !STOP) w_state_nxt = FILL;
         FILL:    if (STOP) w_state_nxt = IDLE;
                  else if (r_timer == FILL_LAST) w_state_nxt = MONITOR;
         MONITOR: if (STOP || r_timer == WIN_LAST) w_state_nxt = REPORT;
`ifdef SHIFTER_AUTO_RERUN_EN
         REPORT:  w_state_nxt = STOP ? IDLE : MONITOR;
`else
         REPORT:  w_state_nxt = IDLE;
`endif
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_start_run = (r_state == IDLE) && (w_state_nxt == FILL);
      w_clear     = w_start_run || ((r_state == REPORT) && (w_state_nxt == MONITOR));
      w_capture   = (r_state == FILL) && (w_state_nxt == MONITOR);
      w_timer_clr = (w_state_nxt != r_state);
      w_enable    = (r_state == MONITOR);
      w_busy_nxt  = (w_state_nxt == FILL) || (w_state_nxt == MONITOR);
      w_done_nxt  = (w_state_nxt == REPORT);
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_timer   <= '0;
         r_pattern <= 1'b1;
         r_fault   <= 2'b00;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         if (w_timer_clr)
            r_timer <= '0;
         else if (r_state == FILL || r_state == MONITOR)
            r_timer <= r_timer + 1'b1;
         if (w_start_run)
            r_pattern <= PATTERN;
         if (w_start_run)
            r_fault <= 2'b00;
         else if (w_capture)
            r_fault <= {w_sync1 != r_pattern, w_sync0 != r_pattern};
      end
   end

   shift_upset_counter #(.CNT_W(CNT_W)) u_chain0 (
      .i_clk(CLK), .i_rst_n(RST), .i_async(SHIFT_OUT0), .i_clear(w_clear),
      .i_enable(w_enable), .i_expected(r_pattern), .o_sync(w_sync0), .o_count(w_cnt0)
   );

   shift_upset_counter #(.CNT_W(CNT_W)) u_chain1 (
      .i_clk(CLK), .i_rst_n(RST), .i_async(SHIFT_OUT1), .i_clear(w_clear),
      .i_enable(w_enable), .i_expected(r_pattern), .o_sync(w_sync1), .o_count(w_cnt1)
   );

`ifdef SHIFTER_AUTO_RERUN_EN
   // Live counters restart every window; the last window's totals are shown until the next DONE.
   logic [CNT_W-1:0] r_hold0, r_hold1;
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_hold0 <= '0;
         r_hold1 <= '0;
      end else if (r_state == REPORT) begin
         r_hold0 <= w_cnt0;
         r_hold1 <= w_cnt1;
      end
   end
   assign SHIFT_ERROR_COUNT0 = (r_state == REPORT) ? w_cnt0 : r_hold0;
   assign SHIFT_ERROR_COUNT1 = (r_state == REPORT) ? w_cnt1 : r_hold1;
`else
   assign SHIFT_ERROR_COUNT0 = w_cnt0;
   assign SHIFT_ERROR_COUNT1 = w_cnt1;
`endif

   assign SHIFT_INPUT0 = r_pattern;
   assign SHIFT_INPUT1 = r_pattern;
   assign CHAIN_FAULT  = r_fault;
   assign BUSY         = r_busy;
   assign DONE         = r_done;
endmodule

// File: tb/tb_shifter_test_ctrl.sv
// tb/tb_shifter_test_ctrl.sv - directed self-checking bench for shifter_test_ctrl
module tb_shifter_test_ctrl;
   logic        clk = 1'b0;
   logic        rst, start, stop, pattern, out0, out1;
   logic        in0, in1, busy, done;
   logic [11:0] cnt0, cnt1;
   logic [1:0]  fault;
   logic        sat_start, sat_out0, sat_in0, sat_in1, sat_busy, sat_done;
   logic [11:0] sat_cnt0, sat_cnt1;
   logic [1:0]  sat_fault;
   int          total = 0;
   int          bad = 0;
   int          busy_n, done_n, done_i;

   always #5 clk = ~clk;

   shifter_test_ctrl #(.FILL_CYCLES(16), .WINDOW_CYCLES(32'd100), .CNT_W(12)) u_dut (
      .CLK(clk), .RST(rst), .START(start), .STOP(stop), .PATTERN(pattern),
      .SHIFT_OUT0(out0), .SHIFT_OUT1(out1), .SHIFT_INPUT0(in0), .SHIFT_INPUT1(in1),
      .SHIFT_ERROR_COUNT0(cnt0), .SHIFT_ERROR_COUNT1(cnt1), .CHAIN_FAULT(fault),
      .BUSY(busy), .DONE(done)
   );

   shifter_test_ctrl #(.FILL_CYCLES(16), .WINDOW_CYCLES(32'd20000), .CNT_W(12)) u_sat (
      .CLK(clk), .RST(rst), .START(sat_start), .STOP(1'b0), .PATTERN(1'b1),
      .SHIFT_OUT0(sat_out0), .SHIFT_OUT1(1'b1), .SHIFT_INPUT0(sat_in0), .SHIFT_INPUT1(sat_in1),
      .SHIFT_ERROR_COUNT0(sat_cnt0), .SHIFT_ERROR_COUNT1(sat_cnt1), .CHAIN_FAULT(sat_fault),
      .BUSY(sat_busy), .DONE(sat_done)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   function automatic logic in_pulse(input int idx, input int a);
      return (a >= 0) && (idx >= a) && (idx < a + 2);
   endfunction

   // Index 0 is the first negedge after the START edge; pulses invert the base level for 2 cycles.
   task automatic run(input logic pat, input logic b0, input logic b1,
                      input int a0, input int a1, input int a2, input int a3,
                      input int start_i, input int stop_i,
                      output int bn, output int dn, output int di);
      bn = 0; dn = 0; di = -1;
      @(negedge clk);
      start = 1'b1; pattern = pat; out0 = b0; out1 = b1;
      @(negedge clk);
      start = 1'b0;
      for (int idx = 0; idx < 200; idx++) begin
         out0  = b0 ^ (in_pulse(idx, a0) | in_pulse(idx, a1) | in_pulse(idx, a2));
         out1  = b1 ^ in_pulse(idx, a3);
         start = (idx == start_i);
         stop  = (idx == stop_i);
         if (busy) bn++;
         if (done) begin dn++; di = idx; end
         @(negedge clk);
      end
      start = 1'b0; stop = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0; pattern = 1'b0; out0 = 1'b1; out1 = 1'b1;
      sat_start = 1'b0; sat_out0 = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_in0", in0, 1);
      check("rst_in1", in1, 1);
      check("rst_cnt0", cnt0, 0);
      check("rst_fault", fault, 0);
      rst = 1'b1;
      @(negedge clk);

      run(1, 1, 1, -1, -1, -1, -1, -1, -1, busy_n, done_n, done_i);
      check("clean_busy_len", busy_n, 116);
      check("clean_done_n", done_n, 1);
      check("clean_done_idx", done_i, 116);
      check("clean_cnt0", cnt0, 0);
      check("clean_cnt1", cnt1, 0);
      check("clean_fault", fault, 0);

      run(1, 1, 1, 14, 50, 113, 60, -1, -1, busy_n, done_n, done_i);
      check("pulse_cnt0", cnt0, 3);
      check("pulse_cnt1", cnt1, 1);
      check("pulse_fault", fault, 0);

      run(1, 1, 1, 5, 114, -1, -1, -1, -1, busy_n, done_n, done_i);
      check("edge_cnt0", cnt0, 0);
      check("edge_fault", fault, 0);

      run(1, 1, 0, -1, -1, -1, -1, -1, -1, busy_n, done_n, done_i);
      check("stuck1_fault", fault, 2);
      check("stuck1_cnt1", cnt1, 0);
      check("stuck1_in1", in1, 1);

      run(0, 0, 0, -1, -1, -1, -1, -1, -1, busy_n, done_n, done_i);
      check("pat0_fault", fault, 0);
      check("pat0_in0", in0, 0);
      check("pat0_cnt0", cnt0, 0);

      run(1, 1, 1, 2, -1, -1, -1, -1, 5, busy_n, done_n, done_i);
      check("stopfill_busy", busy_n, 6);
      check("stopfill_done", done_n, 0);
      check("stopfill_cnt0", cnt0, 0);

      run(1, 1, 1, 30, 60, -1, -1, -1, 56, busy_n, done_n, done_i);
      check("stopmon_busy", busy_n, 57);
      check("stopmon_done_idx", done_i, 57);
      check("stopmon_cnt0", cnt0, 1);

      run(1, 1, 1, -1, -1, -1, -1, 50, -1, busy_n, done_n, done_i);
      check("restart_busy", busy_n, 116);
      check("restart_done_idx", done_i, 116);

      @(negedge clk);
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      check("startstop_busy", busy, 0);
      repeat (5) @(negedge clk);
      check("startstop_busy_late", busy, 0);

      // Reset during MONITOR with pattern 0 so the SHIFT_INPUT return to 1 is visible.
      out0 = 1'b0; out1 = 1'b0;
      @(negedge clk);
      start = 1'b1; pattern = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      out0 = 1'b1;
      repeat (2) @(negedge clk);
      out0 = 1'b0;
      repeat (8) @(negedge clk);
      check("pre_rst_cnt0", cnt0, 1);
      check("pre_rst_in0", in0, 0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_cnt0", cnt0, 0);
      check("midrst_in0", in0, 1);
      check("midrst_done", done, 0);
      rst = 1'b1;
      done_n = 0;
      repeat (150) begin
         if (done) done_n++;
         @(negedge clk);
      end
      check("midrst_no_done", done_n, 0);
      check("midrst_idle", busy, 0);

      sat_start = 1'b1;
      @(negedge clk);
      sat_start = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         sat_out0 = 1'b0;
         @(negedge clk);
         sat_out0 = 1'b1;
         @(negedge clk);
      end
      done_n = 0;
      for (int i = 0; i < 15000 && done_n == 0; i++) begin
         if (sat_done) done_n = 1;
         else @(negedge clk);
      end
      check("sat_done_seen", done_n, 1);
      check("sat_cnt0", sat_cnt0, 4095);
      check("sat_cnt1", sat_cnt1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/shifter_test_ctrl.md
Name: shifter_test_ctrl

Overview:
- Sequences one SET-test run on the two on-chip shift-register chains.
- Fills both chains with a constant pattern, then opens a timed monitor window. Inside the window it counts upsets: the synchronized chain output leaving the expected level.
- Reports per-chain saturating error counts and stuck-chain faults.
- Sits between the host/UART command logic and the chain pads; replaces free-running edge counting with gated, clocked counting.

Parameters:
- FILL_CYCLES, 64, cycles chain inputs are driven before monitoring starts (≥ chain length + 2 sync stages).
- WINDOW_CYCLES, 1000000, monitor window length in CLK cycles (1..2^32-1).
- CNT_W, 12, error counter width.

Ports:
- CLK  input  1  system clock
- RST  input  1  reset, active-low, synchronous to CLK
- START  input  1  one-cycle pulse; begins a run
- STOP  input  1  one-cycle pulse; ends the run early
- PATTERN  input  1  level to drive into the chains; latched on START
- SHIFT_OUT0  input  1  chain 0 output, asynchronous
- SHIFT_OUT1  input  1  chain 1 output, asynchronous
- SHIFT_INPUT0  output  1  chain 0 input drive
- SHIFT_INPUT1  output  1  chain 1 input drive
- SHIFT_ERROR_COUNT0  output  CNT_W  chain 0 upset count
- SHIFT_ERROR_COUNT1  output  CNT_W  chain 1 upset count
- CHAIN_FAULT  output  2  bit i set if chain i output ≠ pattern at end of FILL
- BUSY  output  1  high in FILL or MONITOR
- DONE  output  1  one-cycle pulse when a run completes

Behaviour:
- Reset (RST=0 at a CLK edge) is checked first every cycle:
  - state → IDLE, pattern register = 1, SHIFT_INPUTx = 1
  - counters = 0, CHAIN_FAULT = 0, BUSY = 0, DONE = 0
  - sync flops = 1, cycle timer = 0
  - Reset mid-run aborts the run immediately and does not pulse DONE.
- Each SHIFT_OUTx passes through a 2-flop synchronizer. Let sx = second-stage flop, px = sx delayed one cycle.
- SHIFT_INPUTx always equals the pattern register.
- Upset event for chain x: px == pattern && sx != pattern, i.e. the first cycle the output departs from the expected level. Holding a wrong level counts once; it re-arms only after the output returns to the pattern.
- States:
  - IDLE:
    - START=1 && STOP=0 → latch PATTERN, clear both counters and CHAIN_FAULT, timer = 0, → FILL.
    - START together with STOP → stay IDLE.
  - FILL:
    - Timer counts 0..FILL_CYCLES-1.
    - On the cycle timer == FILL_CYCLES-1: CHAIN_FAULT[x] = (sx != pattern), timer = 0, → MONITOR.
    - STOP → IDLE; no DONE, counters keep their cleared value.
  - MONITOR:
    - Upset events increment counters.
    - On the cycle timer == WINDOW_CYCLES-1, or on STOP, → REPORT. An event in that same final cycle is still counted.
  - REPORT: DONE=1 for exactly one cycle, → IDLE.
- START outside IDLE is ignored. STOP in IDLE or REPORT is ignored.
- Counters saturate at 2^CNT_W-1; no wrap.
- Chains flagged in CHAIN_FAULT are still counted. Event detection compares against the pattern, so a stuck chain produces no events.
- BUSY = (state == FILL || state == MONITOR), registered.
- Latencies:
  - START → BUSY high: 1 cycle.
  - Run length: FILL_CYCLES + WINDOW_CYCLES cycles after START. DONE asserts on the next cycle.
  - Upset at a pad → counter update: 3 cycles.
- Counts are held in IDLE until the next START.

Optional Feature:
- Macro: SHIFTER_AUTO_RERUN_EN.
- Defined:
  - REPORT returns directly to MONITOR (not IDLE), timer = 0, counters cleared, DONE still pulses. Continuous back-to-back windows with no refill.
  - Counts stay readable until the next DONE.
  - Only STOP or reset returns to IDLE. STOP during REPORT → IDLE.
- Undefined: single-shot behaviour above; STOP in REPORT ignored.

Decomposition:
- Package shifter_test_pkg:
  - state enum {IDLE, FILL, MONITOR, REPORT}
  - CNT_W default, timer width (32)
  - sync depth constant (2)
- Sub-module shift_upset_counter, instantiated per chain. Contains the synchronizer, departure detect, and saturating counter. Inputs: clear, enable, expected level.
- The controller holds the FSM, timer, pattern register and fault capture.

Test Plan (FILL_CYCLES=16, WINDOW_CYCLES=100):
- Both outputs held 1, START with PATTERN=1 → BUSY for 116 cycles, one DONE pulse, counts 0/0, CHAIN_FAULT=00.
- During MONITOR, 3 low pulses (each 2 cycles) on SHIFT_OUT0, 1 on SHIFT_OUT1 → counts 3/1. A pulse in the last window cycle is still counted.
- SHIFT_OUT1 tied 0, PATTERN=1 → CHAIN_FAULT=10, count1=0. Repeat with PATTERN=0 → CHAIN_FAULT=00.
- 5000 toggles during a window with WINDOW_CYCLES=20000 → count0 saturates at 4095.
- STOP at FILL cycle 5 → IDLE, no DONE. STOP at MONITOR cycle 40 → DONE next cycle, counts frozen. RST=0 mid-MONITOR → all outputs at reset values next cycle.
- START+STOP same cycle in IDLE → stays IDLE. START during MONITOR → ignored, run timing unchanged.
